// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key encoder.
// Frame FSM states, prefix bytes, ps2_key bit positions, ignore-byte helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int KEY_TGL = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    // Keyboard status/response bytes that never describe a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-cycle debounce.
// Ports: clk_i, rst_ni (sync, active low), line_i (raw async), level_o (filtered).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The level only flips once the synced line has disagreed with it
    // for FILTER_LEN consecutive cycles; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver folding E0/F0/E1 prefixes into ps2_key events.
// Ports: clk_sys, reset_n, ps2_clk, ps2_data, ps2_key[10:0], frame_err, rx_busy.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000,
    parameter int TMR_W       = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        rx_busy
);

    logic clk_f;
    logic dat_f;
    logic clk_f_q;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .line_i  (ps2_clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .line_i  (ps2_data),
        .level_o (dat_f)
    );

    assign fall = clk_f_q & ~clk_f;

    state_e          state_q;
    state_e          state_d;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TMR_W-1:0] wd_q;
    logic            timeout;
    logic            byte_ok;
    logic            err;
    logic            byte_valid_q;
    logic [7:0]      byte_q;
    logic            frame_err_q;
    logic            rx_busy_q;

    // A fall in the timeout cycle takes precedence and restarts the timer.
    assign timeout = (state_q != IDLE) && !fall &&
                     (wd_q == TMR_W'(TIMEOUT_CYC));

    // Frame FSM: state register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:   if (!dat_f) state_d = DATA;
                DATA:   if (bitcnt_q == 3'd7) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP:   state_d = IDLE;
            endcase
        end
    end

    // Frame FSM: outputs.
    always_comb begin
        byte_ok = 1'b0;
        err     = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if (fall && state_q == STOP) begin
            if (dat_f && (^{par_q, shift_q})) begin
                byte_ok = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
    end

    // Frame datapath and watchdog.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_f_q      <= 1'b1;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            wd_q         <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            clk_f_q      <= clk_f;
            byte_valid_q <= byte_ok;
            frame_err_q  <= err;
            rx_busy_q    <= (state_d != IDLE);
            if (state_q == IDLE || fall) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
            if (byte_ok) begin
                byte_q <= shift_q;
            end
            if (fall) begin
                unique case (state_q)
                    IDLE:   bitcnt_q <= '0;
                    DATA: begin
                        shift_q  <= {dat_f, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                    PARITY: par_q <= dat_f;
                    STOP:   bitcnt_q <= '0;
                endcase
            end
        end
    end

    // Byte decoder.
    logic        ext_q;
    logic        ext_d;
    logic        brk_q;
    logic        brk_d;
    logic [2:0]  skip_q;
    logic [2:0]  skip_d;
    logic [10:0] key_q;
    logic [10:0] key_d;

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        if (byte_valid_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (byte_q == PFX_PAUSE) begin
                // Pause sends E1 plus seven more bytes and no break code.
                skip_d = 3'd7;
            end else if (byte_q == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PFX_BRK) begin
                brk_d = 1'b1;
            end else if (ext_q || brk_q || !is_ignored(byte_q)) begin
                key_d[KEY_TGL] = ~key_q[KEY_TGL];
                key_d[KEY_PRS] = ~brk_q;
                key_d[KEY_EXT] = ext_q;
                key_d[7:0]     = byte_q;
                ext_d          = 1'b0;
                brk_d          = 1'b0;
            end
        end
        // A broken frame may have been part of a prefixed sequence.
        if (err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: table of frames plus timeout and reset cases.
// Timing is scaled down (short half-bit, short watchdog) to keep runs small.
module tb_ps2_key_encoder;

    localparam int H       = 20;
    localparam int TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;
    int errp = 0;

    ps2_key_encoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TIMEOUT),
        .TMR_W       (16)
    ) dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) errp <= errp + 1;
    end

    typedef struct {
        logic [7:0]  b;
        bit          bad;
        bit          glitch;
        logic [10:0] key;
        int          errs;
    } vec_t;

    vec_t tv [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad,
                              input bit glitch, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H / 2) @(negedge clk);
            if (glitch && i == 5) begin
                ps2_clk = 1'b0;
                @(negedge clk);
                ps2_clk = 1'b1;
                repeat (H - H / 2 - 1) @(negedge clk);
            end else begin
                repeat (H - H / 2) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        int e0;
        for (int i = lo; i < hi; i++) begin
            e0 = errp;
            send_frame(tv[i].b, tv[i].bad, tv[i].glitch, 11);
            ps2_data = 1'b1;
            repeat (2 * H) @(negedge clk);
            chk($sformatf("row%0d_key", i), 32'(ps2_key), 32'(tv[i].key));
            chk($sformatf("row%0d_err", i), 32'(errp - e0), 32'(tv[i].errs));
            chk($sformatf("row%0d_busy", i), 32'(rx_busy), 32'd0);
        end
    endtask

    initial begin
        int e0;
        int n;

        tv[0]  = '{8'h1C, 0, 0, 11'h61C, 0};
        tv[1]  = '{8'hF0, 0, 0, 11'h61C, 0};
        tv[2]  = '{8'h1C, 0, 0, 11'h01C, 0};
        tv[3]  = '{8'hE0, 0, 0, 11'h01C, 0};
        tv[4]  = '{8'h75, 0, 1, 11'h775, 0};
        tv[5]  = '{8'hE0, 0, 0, 11'h775, 0};
        tv[6]  = '{8'h75, 1, 0, 11'h775, 1};
        tv[7]  = '{8'h6B, 0, 0, 11'h26B, 0};
        tv[8]  = '{8'h29, 0, 0, 11'h629, 0};
        tv[9]  = '{8'hE1, 0, 0, 11'h629, 0};
        tv[10] = '{8'h14, 0, 0, 11'h629, 0};
        tv[11] = '{8'h77, 0, 0, 11'h629, 0};
        tv[12] = '{8'hE1, 0, 0, 11'h629, 0};
        tv[13] = '{8'hF0, 0, 0, 11'h629, 0};
        tv[14] = '{8'h14, 0, 0, 11'h629, 0};
        tv[15] = '{8'hF0, 0, 0, 11'h629, 0};
        tv[16] = '{8'h77, 0, 0, 11'h629, 0};
        tv[17] = '{8'h05, 0, 0, 11'h205, 0};
        tv[18] = '{8'hAA, 0, 0, 11'h205, 0};

        repeat (5) @(negedge clk);
        chk("rst_key", 32'(ps2_key), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        run_rows(0, 8);

        // Abandoned frame: five bits then the clock stays high.
        e0 = errp;
        send_frame(8'h5A, 0, 0, 5);
        ps2_data = 1'b1;
        repeat (200) @(negedge clk);
        chk("to_busy_before", 32'(rx_busy), 32'd1);
        n = 0;
        while (rx_busy === 1'b1 && n < 2 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("to_busy_after", 32'(rx_busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("to_err", 32'(errp - e0), 32'd1);
        chk("to_key", 32'(ps2_key), 32'h26B);

        run_rows(8, 19);

        // Reset in the middle of a frame.
        e0 = errp;
        send_frame(8'h33, 0, 0, 5);
        chk("mid_busy", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_key", 32'(ps2_key), 32'd0);
        chk("mid_rst_err", 32'(frame_err), 32'd0);
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        ps2_data = 1'b1;
        ps2_clk  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h1C, 0, 0, 11);
        repeat (2 * H) @(negedge clk);
        chk("post_rst_key", 32'(ps2_key), 32'h61C);
        chk("post_rst_err", 32'(errp - e0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
